// File: rtl/sprite_compositor.sv
// Pipelined sprite compositor: per-channel hit test and ROM addressing,
// ROM-latency alignment, priority/transparency select and per-frame collision flag.
module sprite_compositor #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned COORD_W     = 10,
    parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
    parameter int unsigned ROM_LAT     = 1,
    localparam int unsigned ADDR_W     = $clog2(4 * SPR_W * SPR_H)
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              pix_valid,
    input  logic                              frame_start,
    input  logic [COORD_W-1:0]                DrawX,
    input  logic [COORD_W-1:0]                DrawY,
    input  logic [NUM_SPRITES*COORD_W-1:0]    spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]    spr_y,
    input  logic [NUM_SPRITES*3-1:0]          spr_dir,
    input  logic [NUM_SPRITES-1:0]            spr_en,
    output logic [NUM_SPRITES*ADDR_W-1:0]     rom_addr,
    input  logic [NUM_SPRITES*24-1:0]         rom_data,
    output logic [7:0]                        VGA_R,
    output logic [7:0]                        VGA_G,
    output logic [7:0]                        VGA_B,
    output logic                              out_valid,
    output logic [NUM_SPRITES-1:0]            hit_mask,
    output logic                              collision
);

    localparam int unsigned SX_W = $clog2(SPR_W);
    localparam int unsigned SY_W = $clog2(SPR_H);
    localparam int unsigned CW1  = COORD_W + 1;

    // Stage A: address register
    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic [NUM_SPRITES-1:0]        hit_a_d, hit_a_q;
    logic                          valid_a_d, valid_a_q;
    logic                          fs_a_d, fs_a_q;

    // Stage B: ROM wait delay line
    logic [NUM_SPRITES-1:0]        hit_b_d [ROM_LAT];
    logic [NUM_SPRITES-1:0]        hit_b_q [ROM_LAT];
    logic [ROM_LAT-1:0]            valid_b_d, valid_b_q;
    logic [ROM_LAT-1:0]            fs_b_d, fs_b_q;

    // Stage C: output register
    logic [23:0]                   rgb_d, rgb_q;
    logic [NUM_SPRITES-1:0]        mask_d, mask_q;
    logic                          out_valid_d, out_valid_q;
    logic                          coll_d, coll_q;

    logic [NUM_SPRITES-1:0]        hit_al;
    logic                          valid_al;
    logic                          fs_al;

    assign hit_al   = hit_b_q[ROM_LAT-1];
    assign valid_al = valid_b_q[ROM_LAT-1];
    assign fs_al    = fs_b_q[ROM_LAT-1];

    // Per-channel bounds/direction test and texel address; bound sums carry an extra bit so they never wrap
    always_comb begin
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [CW1-1:0]     x_end;
        logic [CW1-1:0]     y_end;
        logic [2:0]         dir;
        logic               in_x;
        logic               in_y;
        logic               dir_ok;
        logic               hit;
        sx         = '0;
        sy         = '0;
        dx         = '0;
        dy         = '0;
        x_end      = '0;
        y_end      = '0;
        dir        = '0;
        in_x       = 1'b0;
        in_y       = 1'b0;
        dir_ok     = 1'b0;
        hit        = 1'b0;
        hit_a_d    = '0;
        rom_addr_d = '0;
        valid_a_d  = pix_valid;
        fs_a_d     = pix_valid & frame_start;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sx     = spr_x[i*COORD_W +: COORD_W];
            sy     = spr_y[i*COORD_W +: COORD_W];
            dir    = spr_dir[i*3 +: 3];
            x_end  = CW1'(sx) + CW1'(SPR_W);
            y_end  = CW1'(sy) + CW1'(SPR_H);
            in_x   = (DrawX >= sx) && (CW1'(DrawX) < x_end);
            in_y   = (DrawY >= sy) && (CW1'(DrawY) < y_end);
            dir_ok = (dir >= 3'd1) && (dir <= 3'd4);
            hit    = spr_en[i] && dir_ok && in_x && in_y;
            dx     = DrawX - sx;
            dy     = DrawY - sy;
            hit_a_d[i] = hit;
            if (hit) begin
                rom_addr_d[i*ADDR_W +: ADDR_W] = {2'(dir - 3'd1), dy[SY_W-1:0], dx[SX_W-1:0]};
            end
        end
    end

    // Stage A register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rom_addr_q <= '0;
            hit_a_q    <= '0;
            valid_a_q  <= 1'b0;
            fs_a_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_a_q    <= hit_a_d;
            valid_a_q  <= valid_a_d;
            fs_a_q     <= fs_a_d;
        end
    end

    // Delay hit/valid/frame_start so they line up with rom_data
    always_comb begin
        valid_b_d  = '0;
        fs_b_d     = '0;
        for (int k = 0; k < ROM_LAT; k++) begin
            hit_b_d[k] = '0;
        end
        hit_b_d[0]   = hit_a_q;
        valid_b_d[0] = valid_a_q;
        fs_b_d[0]    = fs_a_q;
        for (int k = 1; k < ROM_LAT; k++) begin
            hit_b_d[k]   = hit_b_q[k-1];
            valid_b_d[k] = valid_b_q[k-1];
            fs_b_d[k]    = fs_b_q[k-1];
        end
    end

    // Stage B register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_b_q <= '0;
            fs_b_q    <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_b_q[k] <= '0;
            end
        end else begin
            valid_b_q <= valid_b_d;
            fs_b_q    <= fs_b_d;
            for (int k = 0; k < ROM_LAT; k++) begin
                hit_b_q[k] <= hit_b_d[k];
            end
        end
    end

    // Transparency, lowest-index priority and overlap detect; bubbles hold colour, mask and flag
    always_comb begin
        logic [23:0]            texel;
        logic [23:0]            sel_rgb;
        logic [NUM_SPRITES-1:0] opaque;
        logic                   seen;
        logic                   multi;
        texel       = '0;
        sel_rgb     = BG_COLOR;
        opaque      = '0;
        seen        = 1'b0;
        multi       = 1'b0;
        rgb_d       = rgb_q;
        mask_d      = mask_q;
        coll_d      = coll_q;
        out_valid_d = valid_al;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            texel     = rom_data[i*24 +: 24];
            opaque[i] = hit_al[i] && (texel != KEY_COLOR);
            if (opaque[i]) begin
                if (!seen) begin
                    sel_rgb = texel;
                end
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        if (valid_al) begin
            rgb_d  = sel_rgb;
            mask_d = opaque;
            coll_d = (fs_al ? 1'b0 : coll_q) | multi;
        end
    end

    // Output register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rgb_q       <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            coll_q      <= coll_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign VGA_R     = rgb_q[23:16];
    assign VGA_G     = rgb_q[15:8];
    assign VGA_B     = rgb_q[7:0];
    assign out_valid = out_valid_q;
    assign hit_mask  = mask_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor at default parameters.
`timescale 1ns/1ps
module tb_sprite_compositor;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [39:0] spr_x = '0;
    logic [39:0] spr_y = '0;
    logic [11:0] spr_dir = '0;
    logic [3:0]  spr_en = '0;
    logic [47:0] rom_addr;
    logic [95:0] rom_data;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        out_valid;
    logic [3:0]  hit_mask;
    logic        collision;

    logic [3:0]  use_const = '0;
    logic [23:0] rom_const [4];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    sprite_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_dir     (spr_dir),
        .spr_en      (spr_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .out_valid   (out_valid),
        .hit_mask    (hit_mask),
        .collision   (collision)
    );

    always #5 Clk = ~Clk;

    // One-cycle sprite ROM: texel equals address, or a per-channel constant
    always @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            rom_data[i*24 +: 24] <= use_const[i] ? rom_const[i] : 24'(rom_addr[i*12 +: 12]);
        end
    end

    task automatic set_sprite(input int ch, input logic [9:0] x, input logic [9:0] y,
                              input logic [2:0] dir, input logic en);
        spr_x[ch*10 +: 10] = x;
        spr_y[ch*10 +: 10] = y;
        spr_dir[ch*3 +: 3] = dir;
        spr_en[ch]         = en;
    endtask

    // Issue one pixel, then count edges until out_valid (bounded)
    task automatic send_pixel(input logic [9:0] x, input logic [9:0] y, input logic fs,
                              output int lat);
        DrawX = x;
        DrawY = y;
        frame_start = fs;
        pix_valid = 1'b1;
        @(posedge Clk); #1;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin err_cnt++; $display("FAIL reset_rgb: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 24'h0); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vec_cnt++; if (hit_mask !== 4'h0) begin err_cnt++; $display("FAIL reset_mask: got %h expected 0", hit_mask); end
        vec_cnt++; if (collision !== 1'b0) begin err_cnt++; $display("FAIL reset_coll: got %b expected 0", collision); end
        vec_cnt++; if (rom_addr !== 48'h0) begin err_cnt++; $display("FAIL reset_addr: got %h expected 0", rom_addr); end
        Reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_background();
        logic exp_v;
        spr_en = '0;
        for (int c = 0; c < 12; c++) begin
            pix_valid   = (c < 8);
            frame_start = (c == 0);
            DrawX       = 10'(c * 7);
            DrawY       = 10'd7;
            @(posedge Clk); #1;
            exp_v = (c >= 2) && (c <= 9);
            vec_cnt++; if (out_valid !== exp_v) begin err_cnt++; $display("FAIL bg_valid[%0d]: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin err_cnt++; $display("FAIL bg_rgb[%0d]: got %h expected ffffff", c, {VGA_R, VGA_G, VGA_B}); end
                vec_cnt++; if (hit_mask !== 4'h0 || collision !== 1'b0) begin err_cnt++; $display("FAIL bg_mask_coll[%0d]: got %h/%b expected 0/0", c, hit_mask, collision); end
            end
        end
        pix_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_single_sprite();
        int lat;
        use_const = '0;
        set_sprite(0, 10'd100, 10'd50, 3'd2, 1'b1);
        DrawX = 10'd105; DrawY = 10'd52; frame_start = 1'b0; pix_valid = 1'b1;
        @(posedge Clk); #1;
        pix_valid = 1'b0;
        vec_cnt++; if (rom_addr[11:0] !== 12'd1093) begin err_cnt++; $display("FAIL single_addr: got %0d expected 1093", rom_addr[11:0]); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_early1: got %b expected 0", out_valid); end
        @(posedge Clk); #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_early2: got %b expected 0", out_valid); end
        @(posedge Clk); #1;
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000445) begin err_cnt++; $display("FAIL single_rgb: got %h expected 000445", {VGA_R, VGA_G, VGA_B}); end
        vec_cnt++; if (hit_mask !== 4'b0001) begin err_cnt++; $display("FAIL single_mask: got %b expected 0001", hit_mask); end
        send_pixel(10'd132, 10'd52, 1'b0, lat);
        vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL right_edge_lat: got %0d expected 3", lat); end
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || hit_mask !== 4'h0) begin err_cnt++; $display("FAIL right_edge_miss: got %h/%b expected ffffff/0000", {VGA_R, VGA_G, VGA_B}, hit_mask); end
        send_pixel(10'd131, 10'd81, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0007FF || hit_mask !== 4'b0001) begin err_cnt++; $display("FAIL corner_hit: got %h/%b expected 0007ff/0001", {VGA_R, VGA_G, VGA_B}, hit_mask); end
        send_pixel(10'd99, 10'd52, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || hit_mask !== 4'h0) begin err_cnt++; $display("FAIL left_edge_miss: got %h/%b expected ffffff/0000", {VGA_R, VGA_G, VGA_B}, hit_mask); end
        vec_cnt++; if (collision !== 1'b0) begin err_cnt++; $display("FAIL single_coll: got %b expected 0", collision); end
    endtask

    task automatic test_priority();
        int lat;
        set_sprite(0, 10'd0, 10'd0, 3'd1, 1'b1);
        set_sprite(1, 10'd0, 10'd0, 3'd1, 1'b1);
        use_const    = 4'b0011;
        rom_const[0] = 24'hFF0000;
        rom_const[1] = 24'h00FF00;
        send_pixel(10'd3, 10'd3, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h00FF00) begin err_cnt++; $display("FAIL key_rgb: got %h expected 00ff00", {VGA_R, VGA_G, VGA_B}); end
        vec_cnt++; if (hit_mask !== 4'b0010) begin err_cnt++; $display("FAIL key_mask: got %b expected 0010", hit_mask); end
        vec_cnt++; if (collision !== 1'b0) begin err_cnt++; $display("FAIL key_coll: got %b expected 0", collision); end
        rom_const[0] = 24'h123456;
        send_pixel(10'd3, 10'd3, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin err_cnt++; $display("FAIL prio_rgb: got %h expected 123456", {VGA_R, VGA_G, VGA_B}); end
        vec_cnt++; if (hit_mask !== 4'b0011) begin err_cnt++; $display("FAIL prio_mask: got %b expected 0011", hit_mask); end
        vec_cnt++; if (collision !== 1'b1) begin err_cnt++; $display("FAIL prio_coll: got %b expected 1", collision); end
    endtask

    task automatic test_collision();
        int lat;
        send_pixel(10'd200, 10'd200, 1'b0, lat);
        vec_cnt++; if (collision !== 1'b1) begin err_cnt++; $display("FAIL coll_sticky: got %b expected 1", collision); end
        vec_cnt++; if (hit_mask !== 4'h0) begin err_cnt++; $display("FAIL coll_sticky_mask: got %b expected 0000", hit_mask); end
        send_pixel(10'd200, 10'd200, 1'b1, lat);
        vec_cnt++; if (collision !== 1'b0) begin err_cnt++; $display("FAIL coll_clear: got %b expected 0", collision); end
        send_pixel(10'd3, 10'd3, 1'b0, lat);
        vec_cnt++; if (collision !== 1'b1) begin err_cnt++; $display("FAIL coll_set: got %b expected 1", collision); end
        send_pixel(10'd3, 10'd3, 1'b1, lat);
        vec_cnt++; if (collision !== 1'b1) begin err_cnt++; $display("FAIL coll_fs_overlap: got %b expected 1", collision); end
        vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL coll_lat: got %0d expected 3", lat); end
    endtask

    task automatic test_edges();
        int          lat;
        logic [2:0]  dirs [3];
        logic [11:0] exp_addr [3];
        logic [23:0] exp_rgb [3];
        logic [3:0]  exp_mask [3];
        dirs[0] = 3'd0; exp_addr[0] = 12'd0;    exp_rgb[0] = 24'hFFFFFF; exp_mask[0] = 4'b0000;
        dirs[1] = 3'd5; exp_addr[1] = 12'd0;    exp_rgb[1] = 24'hFFFFFF; exp_mask[1] = 4'b0000;
        dirs[2] = 3'd4; exp_addr[2] = 12'd3137; exp_rgb[2] = 24'h000C41; exp_mask[2] = 4'b0001;
        use_const = '0;
        set_sprite(1, 10'd0, 10'd0, 3'd1, 1'b0);
        set_sprite(0, 10'd1020, 10'd0, 3'd1, 1'b1);
        send_pixel(10'd5, 10'd5, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || hit_mask !== 4'h0) begin err_cnt++; $display("FAIL nowrap: got %h/%b expected ffffff/0000", {VGA_R, VGA_G, VGA_B}, hit_mask); end
        send_pixel(10'd1023, 10'd5, 1'b0, lat);
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0000A3 || hit_mask !== 4'b0001) begin err_cnt++; $display("FAIL screen_edge: got %h/%b expected 0000a3/0001", {VGA_R, VGA_G, VGA_B}, hit_mask); end
        for (int t = 0; t < 3; t++) begin
            set_sprite(0, 10'd0, 10'd0, dirs[t], 1'b1);
            DrawX = 10'd1; DrawY = 10'd2; pix_valid = 1'b1;
            @(posedge Clk); #1;
            pix_valid = 1'b0;
            vec_cnt++; if (rom_addr[11:0] !== exp_addr[t]) begin err_cnt++; $display("FAIL dir%0d_addr: got %0d expected %0d", dirs[t], rom_addr[11:0], exp_addr[t]); end
            repeat (2) @(posedge Clk);
            #1;
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL dir%0d_valid: got %b expected 1", dirs[t], out_valid); end
            vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== exp_rgb[t] || hit_mask !== exp_mask[t]) begin err_cnt++; $display("FAIL dir%0d_out: got %h/%b expected %h/%b", dirs[t], {VGA_R, VGA_G, VGA_B}, hit_mask, exp_rgb[t], exp_mask[t]); end
        end
    endtask

    task automatic test_bubbles();
        logic [9:0] xs [9];
        logic       vin [9];
        logic       exp_v [9];
        logic [7:0] exp_b [9];
        xs = '{10'd1, 10'd2, 10'd4, 10'd4, 10'd5, 10'd6, 10'd6, 10'd6, 10'd6};
        vin = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_b = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h05, 8'h06, 8'h06};
        use_const = '0;
        set_sprite(0, 10'd0, 10'd0, 3'd1, 1'b1);
        DrawY = 10'd0;
        for (int c = 0; c < 9; c++) begin
            DrawX = xs[c];
            pix_valid = vin[c];
            @(posedge Clk); #1;
            vec_cnt++; if (out_valid !== exp_v[c]) begin err_cnt++; $display("FAIL gap_valid[%0d]: got %b expected %b", c, out_valid, exp_v[c]); end
            if (c >= 2) begin
                vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== {16'h0000, exp_b[c]} || hit_mask !== 4'b0001) begin err_cnt++; $display("FAIL gap_out[%0d]: got %h/%b expected %h/0001", c, {VGA_R, VGA_G, VGA_B}, hit_mask, {16'h0000, exp_b[c]}); end
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        int lat;
        vec_cnt++; if (collision !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_coll: got %b expected 1", collision); end
        use_const = '0;
        set_sprite(0, 10'd0, 10'd0, 3'd1, 1'b1);
        DrawY = 10'd0;
        for (int c = 0; c < 3; c++) begin
            DrawX = 10'(10 + c);
            pix_valid = 1'b1;
            @(posedge Clk); #1;
        end
        pix_valid = 1'b0;
        vec_cnt++; if (out_valid !== 1'b1 || {VGA_R, VGA_G, VGA_B} !== 24'h00000A) begin err_cnt++; $display("FAIL pre_reset_out: got %b/%h expected 1/00000a", out_valid, {VGA_R, VGA_G, VGA_B}); end
        #2 Reset = 1'b0;
        #1;
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_out: got %h/%b expected 000000/0", {VGA_R, VGA_G, VGA_B}, out_valid); end
        vec_cnt++; if (hit_mask !== 4'h0 || collision !== 1'b0 || rom_addr !== 48'h0) begin err_cnt++; $display("FAIL async_rst_state: got %b/%b/%h expected 0000/0/0", hit_mask, collision, rom_addr); end
        @(posedge Clk); #1;
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flushed[%0d]: got %b expected 0", c, out_valid); end
        end
        send_pixel(10'd13, 10'd0, 1'b0, lat);
        vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL post_reset_lat: got %0d expected 3", lat); end
        vec_cnt++; if ({VGA_R, VGA_G, VGA_B} !== 24'h00000D) begin err_cnt++; $display("FAIL post_reset_rgb: got %h expected 00000d", {VGA_R, VGA_G, VGA_B}); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rom_const[i] = '0;
        test_reset();
        test_background();
        test_single_sprite();
        test_priority();
        test_collision();
        test_edges();
        test_bubbles();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
